// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer for one shared combinational mod_mul.
// Every exponent bit costs exactly one MUL cycle and one SQR cycle, whatever its value.
module mod_exp_ctrl #(
    parameter int unsigned LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] base,
    input  logic [LEN-1:0] exp,
    input  logic [LEN-1:0] modulus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [LEN-1:0] result,
    output logic           mul_en,
    output logic [LEN-1:0] mul_a,
    output logic [LEN-1:0] mul_b,
    output logic [LEN-1:0] mul_r,
    input  logic [LEN-1:0] mul_c
);

    localparam int unsigned CW = $clog2(LEN);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SQR,
        FIN
    } state_t;

    state_t          state;
    logic [LEN-1:0]  mod_q;
    logic [LEN-1:0]  acc;
    logic [LEN-1:0]  b;
    logic [LEN-1:0]  e;
    logic [CW-1:0]   cnt;

    // Multiplier operands are registered for the state being entered, so the
    // values loaded on each transition are the ones that state will present.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mod_q  <= '0;
            acc    <= '0;
            b      <= '0;
            e      <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_r  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mod_q <= modulus;
                        b     <= base;
                        e     <= exp;
                        acc   <= LEN'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (modulus < LEN'(2) || base >= modulus) begin
                            state  <= FIN;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            result <= '0;
                        end else begin
                            state  <= MUL;
                            err    <= 1'b0;
                            mul_en <= 1'b1;
                            mul_a  <= LEN'(1);
                            mul_b  <= base;
                            mul_r  <= modulus;
                        end
                    end
                end

                MUL: begin
                    // Product is always computed; only the write-back depends on the bit.
                    if (e[0]) begin
                        acc <= mul_c;
                    end
                    state <= SQR;
                    mul_a <= b;
                    mul_b <= b;
                    mul_r <= mod_q;
                end

                SQR: begin
                    b   <= mul_c;
                    e   <= e >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(LEN - 1)) begin
                        state  <= FIN;
                        done   <= 1'b1;
                        err    <= 1'b0;
                        result <= acc;
                        mul_en <= 1'b0;
                        mul_a  <= '0;
                        mul_b  <= '0;
                        mul_r  <= '0;
                    end else begin
                        state <= MUL;
                        mul_a <= acc;
                        mul_b <= mul_c;
                        mul_r <= mod_q;
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mul_en <= 1'b0;
                    mul_a  <= '0;
                    mul_b  <= '0;
                    mul_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Sequences one shared combinational modular multiplier (a*b mod r) to compute base^exp mod modulus by right-to-left square-and-multiply.
- Sits between the Schnorr signing/verification control and the mod_mul datapath. It produces g^k and y^e style terms over the prime field (e.g. p = 2147483647).
- Fixed-schedule, constant-time: every exponent bit costs exactly two multiplier cycles regardless of its value.

Parameters:
- LEN, 32, operand width in bits for base, exp, modulus and the multiplier bus; matches the codebase len.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- base  input  LEN  base operand, must be < modulus
- exp  input  LEN  exponent, unsigned
- modulus  input  LEN  modulus r, must be >= 2
- busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive
- done  output  1  one-cycle pulse; result and err are valid in this cycle
- err  output  1  invalid operands flag; updated when done pulses, held until the next accepted start
- result  output  LEN  base^exp mod modulus; held until the next accepted start
- mul_en  output  1  high in MUL and SQR states; the multiplier's external arbiter must grant while high
- mul_a  output  LEN  multiplier operand a
- mul_b  output  LEN  multiplier operand b
- mul_r  output  LEN  multiplier modulus; always the latched modulus
- mul_c  input  LEN  combinational product (mul_a*mul_b) mod mul_r, valid in the same cycle

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, result=0, mul_en=0, mul_a=mul_b=mul_r=0; internal registers acc, b, e, cnt cleared.
- Reset mid-operation aborts immediately. No done pulse is issued for the aborted job.
- States: IDLE, MUL, SQR, FIN.
- IDLE:
  - mul_en=0, mul_a=mul_b=0.
  - On start=1, latch mod_q=modulus, b=base, e=exp, acc=1, cnt=0; clear err.
  - If modulus<2 or base>=modulus, go to FIN with err pending. Otherwise go to MUL.
- MUL:
  - mul_a=acc, mul_b=b.
  - At edge: acc <= e[0] ? mul_c : acc. The multiply is always issued, independent of the bit value.
  - Next state SQR.
- SQR:
  - mul_a=b, mul_b=b.
  - At edge: b <= mul_c; e <= e>>1; cnt <= cnt+1.
  - If cnt==LEN-1, go to FIN; else go to MUL.
- FIN:
  - done=1 for exactly one cycle.
  - Valid job: result=acc, err=0.
  - Error job: result=0, err=1.
  - Next state IDLE; start is not sampled in FIN.
- Latency:
  - Valid job: start sampled at edge T, done high in cycle T+2*LEN+1 (65 cycles for LEN=32).
  - Error job: done high in cycle T+1.
- busy: busy=1 exactly in MUL, SQR and FIN.
- start while busy is ignored: no latch, no queueing.
- Input stability: base, exp and modulus are needed only in the start cycle and may change afterwards.
- exp=0 yields result 1, including base=0.
- Arithmetic:
  - All internal values stay < mod_q because base < mod_q and mul_c < mul_r.
  - No width growth; reduction is owned by the multiplier.
- Multiplier bus: mul_r=mod_q whenever mul_en=1, else 0.
- No stalls: the arbiter must hold the multiplier granted for the whole job.

Test Plan:
- Reset, then start with base=3, exp=4, modulus=2147483647 -> done 65 cycles after start, result=81, err=0, busy high throughout.
- base=5, exp=3, modulus=13 -> result=8. Separately base=2, exp=31, modulus=2147483647 -> result=1.
- Fermat check: base=290987904, exp=2147483646, modulus=2147483647 -> result=1.
- exp=0 with base=0, modulus=13 -> result=1 after 65 cycles. modulus=1 -> err=1, result=0, done one cycle after start. base=13, modulus=13 -> err=1.
- Start a job, pulse start again with different operands at cycle 10 -> second start ignored, first job's result unchanged. Assert rst at cycle 20 -> next cycle IDLE, all outputs 0, no done pulse.
- Check mul_en/mul_a/mul_b every cycle against the MUL/SQR schedule. Confirm the total cycle count is identical for exp=0x00000000 and exp=0xFFFFFFFF.
